game_ctrl: RTL and testbench
============================

GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 Parameter H_ACT, 640: active pixels per line; the frame event fires at x==0 of line V_ACT.
REQ-002 Parameter V_ACT, 480: active lines per frame.
REQ-003 Parameter LIVES, 3: lives loaded on game start, 1..3.
REQ-004 Parameter OVER_FRAMES, 180: frames spent in OVER before the automatic return to IDLE.
REQ-005 clk  in  1  pixel clock (25.175 MHz); the only clock.
REQ-006 rst  in  1  reset, synchronous, active-low.
REQ-007 x  in  10  current pixel column from the sync generator, 0..799.
REQ-008 y  in  10  current line from the sync generator, 0..524.
REQ-009 key  in  5  debounced key levels; unused except for being held through PAUSE.
REQ-010 key_pulse  in  5  one-cycle key-press pulses, one bit per key.
REQ-011 hit  in  1  one-cycle pulse from the drawing datapath: target scored.
REQ-012 miss  in  1  one-cycle pulse from the drawing datapath: object lost.
REQ-013 state  out  2  game state: IDLE=0, PLAY=1, PAUSE=2, OVER=3.
REQ-014 frame_tick  out  1  one-cycle pulse, once per frame.
REQ-015 update_en  out  1  one-cycle pulse permitting the datapath to advance object positions.
REQ-016 lives  out  2  remaining lives.
REQ-017 score  out  12  three BCD digits, [11:8] hundreds, [3:0] ones.
REQ-018 level  out  3  difficulty level, 1..7.

Function
REQ-019 frame_tick SHALL be registered, asserting the cycle after the cycle where (x==0 && y==V_ACT), for exactly one cycle per frame.
REQ-020 update_en SHALL equal frame_tick gated with state==PLAY, registered in the same cycle.
REQ-021 Start = key_pulse[KB_START]; pause = key_pulse[KB_PAUSE]; all other key_pulse bits SHALL be ignored.
REQ-022 IDLE, start: SHALL go to PLAY, set score=0, lives=LIVES, level=1.
REQ-023 PLAY, pause: SHALL go to PAUSE; PAUSE, pause: SHALL go to PLAY; start SHALL be ignored in both states.
REQ-024 PLAY, hit: score SHALL increment in BCD, saturating at 999.
REQ-025 Level SHALL increment when the ones digit wraps 9->0, saturating at 7; no increment once score is saturated.
REQ-026 PLAY, miss, lives>1: lives SHALL decrement; PLAY, miss, lives==1: lives SHALL become 0 and state SHALL become OVER.
REQ-027 hit and miss in the same cycle: both SHALL be applied (score first, then lives) in one cycle.
REQ-028 miss leading to OVER and pause in the same cycle: OVER SHALL win.
REQ-029 hit and miss SHALL be ignored outside PLAY.
REQ-030 OVER: score, lives and level SHALL hold; start or the OVER_FRAMES-th frame_tick SHALL return to IDLE.
REQ-031 The frame counter SHALL clear on entry to OVER.
REQ-032 All state updates SHALL take effect on the clock edge after the triggering pulse (latency 1).

Reset
REQ-033 On rst==0 at a clock edge, reset SHALL override any event in flight, including mid-game and mid-OVER.
REQ-034 Reset values: state=IDLE, frame_tick=0, update_en=0, lives=0, score=0, level=1, frame counter=0.

Structure
REQ-035 Package game_pkg SHALL hold the state encodings, KB_START=4, KB_PAUSE=0 and the BCD width constant.
REQ-036 Sub-module bcd_counter3 SHALL implement the 3-digit saturating BCD counter with inc and clr inputs and a ones-wrap output.
REQ-037 No other sub-modules; the FSM, frame detection and lives logic SHALL be local.

Verification
REQ-038 Reset, then run 2 full frames -> frame_tick pulses 420000 cycles apart; update_en=0 in IDLE.
REQ-039 Start, then 12 hits -> score=0x012, level=2; update_en pulses every frame.
REQ-040 Preset score 998 via hits, then 3 hits -> score=0x999; level stays saturated at its reached value.
REQ-041 Start, then 3 misses, the third coinciding with pause -> lives=0, state=OVER; after 180 frame_ticks, state=IDLE.
REQ-042 PLAY, pause -> state=PAUSE; hit ignored, update_en=0; pause again -> PLAY with score unchanged.
REQ-043 Reset asserted in PAUSE with hit and miss pulsing -> all outputs at reset values on the next cycle.

Source files
------------

// File: rtl/game_pkg.sv
// ============================================================================
// Module   : game_pkg
// Purpose  : Shared game-state encodings, key-bit indices and score width.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_PAUSE = 2'd2,
        ST_OVER  = 2'd3
    } game_state_t;

    localparam int KB_START = 4;
    localparam int KB_PAUSE = 0;
    localparam int KEY_W    = 5;
    localparam int BCD_W    = 12;

endpackage

`default_nettype wire

// File: rtl/bcd_counter3.sv
// ============================================================================
// Module   : bcd_counter3
// Purpose  : Three-digit BCD counter, saturating at 999, with sync clear.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module bcd_counter3
    import game_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [BCD_W-1:0] count,
    output logic             ones_wrap
);

    logic [3:0] r_d0;
    logic [3:0] r_d1;
    logic [3:0] r_d2;
    logic       w_sat;
    logic       w_step;

    assign w_sat     = (r_d2 == 4'd9) && (r_d1 == 4'd9) && (r_d0 == 4'd9);
    assign w_step    = inc && !w_sat;
    // Only a real step can wrap the ones digit; a saturated count never does.
    assign ones_wrap = w_step && (r_d0 == 4'd9);
    assign count     = {r_d2, r_d1, r_d0};

    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            r_d0 <= 4'd0;
            r_d1 <= 4'd0;
            r_d2 <= 4'd0;
        end else if (w_step) begin
            if (r_d0 == 4'd9) begin
                r_d0 <= 4'd0;
                if (r_d1 == 4'd9) begin
                    r_d1 <= 4'd0;
                    r_d2 <= r_d2 + 4'd1;
                end else begin
                    r_d1 <= r_d1 + 4'd1;
                end
            end else begin
                r_d0 <= r_d0 + 4'd1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/game_ctrl.sv
// ============================================================================
// Module   : game_ctrl
// Purpose  : Game state machine, per-frame tick, lives, level and score.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module game_ctrl
    import game_pkg::*;
#(
    parameter int H_ACT       = 640,
    parameter int V_ACT       = 480,
    parameter int LIVES       = 3,
    parameter int OVER_FRAMES = 180
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [9:0]       x,
    input  logic [9:0]       y,
    input  logic [KEY_W-1:0] key,
    input  logic [KEY_W-1:0] key_pulse,
    input  logic             hit,
    input  logic             miss,
    output logic [1:0]       state,
    output logic             frame_tick,
    output logic             update_en,
    output logic [1:0]       lives,
    output logic [BCD_W-1:0] score,
    output logic [2:0]       level
);

    localparam int FCNT_W = $clog2(OVER_FRAMES + 1);

    game_state_t       r_state;
    game_state_t       w_state_nx;
    logic              r_frame_tick;
    logic              r_update_en;
    logic [1:0]        r_lives;
    logic [1:0]        w_lives_nx;
    logic [2:0]        r_level;
    logic [2:0]        w_level_nx;
    logic [FCNT_W-1:0] r_fcnt;
    logic [FCNT_W-1:0] w_fcnt_nx;
    logic              w_frame_evt;
    logic              w_start;
    logic              w_pause;
    logic              w_inc;
    logic              w_clr;
    logic              w_ones_wrap;
    logic              w_unused;

    assign w_frame_evt = (x == 10'd0) && (y == 10'(V_ACT));
    assign w_start     = key_pulse[KB_START];
    assign w_pause     = key_pulse[KB_PAUSE];
    assign w_inc       = hit && (r_state == ST_PLAY);
    assign w_unused    = ^{key, key_pulse[3:1], (x >= 10'(H_ACT))};

    bcd_counter3 u_score (
        .clk       (clk),
        .rst       (rst),
        .inc       (w_inc),
        .clr       (w_clr),
        .count     (score),
        .ones_wrap (w_ones_wrap)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_frame_tick <= 1'b0;
            r_update_en  <= 1'b0;
            r_lives      <= 2'd0;
            r_level      <= 3'd1;
            r_fcnt       <= '0;
        end else begin
            r_state      <= w_state_nx;
            r_frame_tick <= w_frame_evt;
            r_update_en  <= w_frame_evt && (r_state == ST_PLAY);
            r_lives      <= w_lives_nx;
            r_level      <= w_level_nx;
            r_fcnt       <= w_fcnt_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_lives_nx = r_lives;
        w_level_nx = r_level;
        w_fcnt_nx  = r_fcnt;
        w_clr      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_state_nx = ST_PLAY;
                    w_clr      = 1'b1;
                    w_lives_nx = 2'(LIVES);
                    w_level_nx = 3'd1;
                end
            end
            ST_PLAY: begin
                if (w_ones_wrap && (r_level != 3'd7)) begin
                    w_level_nx = r_level + 3'd1;
                end
                if (w_pause) begin
                    w_state_nx = ST_PAUSE;
                end
                // Losing the last life overrides a simultaneous pause.
                if (miss) begin
                    if (r_lives > 2'd1) begin
                        w_lives_nx = r_lives - 2'd1;
                    end else begin
                        w_lives_nx = 2'd0;
                        w_state_nx = ST_OVER;
                        w_fcnt_nx  = '0;
                    end
                end
            end
            ST_PAUSE: begin
                if (w_pause) begin
                    w_state_nx = ST_PLAY;
                end
            end
            ST_OVER: begin
                if (w_start) begin
                    w_state_nx = ST_IDLE;
                end else if (r_frame_tick) begin
                    if (r_fcnt == FCNT_W'(OVER_FRAMES - 1)) begin
                        w_state_nx = ST_IDLE;
                    end else begin
                        w_fcnt_nx = r_fcnt + FCNT_W'(1);
                    end
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    assign state      = r_state;
    assign frame_tick = r_frame_tick;
    assign update_en  = r_update_en;
    assign lives      = r_lives;
    assign level      = r_level;

endmodule

`default_nettype wire

// File: tb/tb_game_ctrl.sv
// ============================================================================
// Module   : tb_game_ctrl
// Purpose  : Self-checking bench for game_ctrl with a small raster.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_game_ctrl;

    localparam int TB_H_ACT  = 12;
    localparam int TB_V_ACT  = 6;
    localparam int H_TOT     = 16;
    localparam int V_TOT     = 10;
    localparam int FRAME_CYC = H_TOT * V_TOT;
    localparam int NLIVES    = 3;
    localparam int OVF       = 180;
    localparam int S_IDLE = 0, S_PLAY = 1, S_PAUSE = 2, S_OVER = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  x, y;
    logic [4:0]  key, key_pulse;
    logic        hit, miss;
    logic [1:0]  state;
    logic        frame_tick, update_en;
    logic [1:0]  lives;
    logic [11:0] score;
    logic [2:0]  level;

    int n_checks = 0;
    int n_errs   = 0;
    int cyc      = 0;
    int gx       = 0;
    int gy       = 0;

    // Reference model: plain integers for state, decimal score, lives, level.
    int m_state = S_IDLE, m_score = 0, m_lives = 0, m_level = 1, m_ovr = 0;
    int m_ft = 0, m_ue = 0;

    game_ctrl #(
        .H_ACT       (TB_H_ACT),
        .V_ACT       (TB_V_ACT),
        .LIVES       (NLIVES),
        .OVER_FRAMES (OVF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .x          (x),
        .y          (y),
        .key        (key),
        .key_pulse  (key_pulse),
        .hit        (hit),
        .miss       (miss),
        .state      (state),
        .frame_tick (frame_tick),
        .update_en  (update_en),
        .lives      (lives),
        .score      (score),
        .level      (level)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic model_step();
        int ns;
        int evt;
        int prev_ft;
        if (!rst) begin
            m_state = S_IDLE; m_score = 0; m_lives = 0; m_level = 1;
            m_ovr = 0; m_ft = 0; m_ue = 0;
        end else begin
            evt     = (x == 10'd0 && y == 10'(TB_V_ACT)) ? 1 : 0;
            ns      = m_state;
            prev_ft = m_ft;
            case (m_state)
                S_IDLE: if (key_pulse[4]) begin
                    ns = S_PLAY; m_score = 0; m_lives = NLIVES; m_level = 1;
                end
                S_PLAY: begin
                    if (hit && m_score < 999) begin
                        m_score++;
                        if (m_score % 10 == 0 && m_level < 7) m_level++;
                    end
                    if (key_pulse[0]) ns = S_PAUSE;
                    if (miss) begin
                        if (m_lives > 1) m_lives--;
                        else begin m_lives = 0; ns = S_OVER; m_ovr = 0; end
                    end
                end
                S_PAUSE: if (key_pulse[0]) ns = S_PLAY;
                default: begin
                    if (key_pulse[4]) ns = S_IDLE;
                    else if (prev_ft != 0) begin
                        m_ovr++;
                        if (m_ovr == OVF) ns = S_IDLE;
                    end
                end
            endcase
            m_ue    = (evt != 0 && m_state == S_PLAY) ? 1 : 0;
            m_ft    = evt;
            m_state = ns;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        check_eq("outputs", {11'd0, state, frame_tick, update_en, lives, score, level},
                 {11'd0, 2'(m_state), m_ft[0], m_ue[0], 2'(m_lives), to_bcd(m_score), 3'(m_level)});
        gx++;
        if (gx == H_TOT) begin
            gx = 0;
            gy = (gy == V_TOT - 1) ? 0 : gy + 1;
        end
        x = 10'(gx);
        y = 10'(gy);
        hit = 1'b0;
        miss = 1'b0;
        key_pulse = 5'd0;
    endtask

    task automatic check_reset_vals(input string pfx);
        check_eq({pfx, "_state"}, 32'(state), 32'd0);
        check_eq({pfx, "_ft"},    32'(frame_tick), 32'd0);
        check_eq({pfx, "_ue"},    32'(update_en), 32'd0);
        check_eq({pfx, "_lives"}, 32'(lives), 32'd0);
        check_eq({pfx, "_score"}, 32'(score), 32'd0);
        check_eq({pfx, "_level"}, 32'(level), 32'd1);
    endtask

    initial begin
        int t[3];
        int nt;
        int cnt;
        rst = 1'b0; x = '0; y = '0; key = '0; key_pulse = '0; hit = 1'b0; miss = 1'b0;

        repeat (3) tick();
        check_reset_vals("reset");
        rst = 1'b1;

        // Frame tick spacing in IDLE
        nt = 0; cnt = 0;
        for (int i = 0; i < 3 * FRAME_CYC + 10 && nt < 3; i++) begin
            tick();
            if (update_en) cnt++;
            if (frame_tick) begin t[nt] = cyc; nt++; end
        end
        check_eq("ft_count", 32'(nt), 32'd3);
        check_eq("ft_period0", 32'(t[1] - t[0]), 32'(FRAME_CYC));
        check_eq("ft_period1", 32'(t[2] - t[1]), 32'(FRAME_CYC));
        check_eq("ue_idle", 32'(cnt), 32'd0);

        // Start and 12 hits
        key_pulse = 5'h10 | (5'($urandom) & 5'h0E);
        tick();
        check_eq("start_state", 32'(state), 32'(S_PLAY));
        check_eq("start_lives", 32'(lives), 32'(NLIVES));
        for (int i = 0; i < 12; i++) begin
            hit = 1'b1; key = 5'($urandom); key_pulse = 5'($urandom) & 5'h0E;
            tick();
            repeat ($urandom_range(0, 3)) tick();
        end
        check_eq("score_12", 32'(score), 32'h012);
        check_eq("level_12", 32'(level), 32'd2);
        cnt = 0;
        repeat (2 * FRAME_CYC) begin tick(); if (update_en) cnt++; end
        check_eq("ue_play", 32'(cnt), 32'd2);

        // Saturation at 999
        repeat (986) begin hit = 1'b1; tick(); end
        check_eq("score_998", 32'(score), 32'h998);
        repeat (3) begin hit = 1'b1; tick(); end
        check_eq("score_sat", 32'(score), 32'h999);
        check_eq("level_sat", 32'(level), 32'd7);

        // Pause behaviour
        key_pulse = 5'h01; tick();
        check_eq("pause_state", 32'(state), 32'(S_PAUSE));
        hit = 1'b1; miss = 1'b1; key_pulse = 5'h10; tick();
        cnt = 0;
        repeat (FRAME_CYC) begin tick(); if (update_en) cnt++; end
        check_eq("ue_pause", 32'(cnt), 32'd0);
        check_eq("pause_lives", 32'(lives), 32'(NLIVES));
        key_pulse = 5'h01; tick();
        check_eq("resume_state", 32'(state), 32'(S_PLAY));
        check_eq("resume_score", 32'(score), 32'h999);

        // Three misses, the last with pause
        miss = 1'b1; tick(); tick();
        miss = 1'b1; tick();
        check_eq("lives_1", 32'(lives), 32'd1);
        miss = 1'b1; key_pulse = 5'h01; tick();
        check_eq("over_state", 32'(state), 32'(S_OVER));
        check_eq("over_lives", 32'(lives), 32'd0);
        nt = (frame_tick && state == 2'(S_OVER)) ? 1 : 0;
        for (int i = 0; i < (OVF + 2) * FRAME_CYC && state != 2'(S_IDLE); i++) begin
            tick();
            if (frame_tick && state == 2'(S_OVER)) nt++;
        end
        check_eq("over_frames", 32'(nt), 32'(OVF));
        check_eq("over_exit", 32'(state), 32'(S_IDLE));
        check_eq("over_hold", 32'(score), 32'h999);

        // Reset in PAUSE with a frame event and pulses in flight
        key_pulse = 5'h10; tick();
        key_pulse = 5'h01; tick();
        check_eq("pause2_state", 32'(state), 32'(S_PAUSE));
        for (int i = 0; i < FRAME_CYC + 2 && !(gx == 0 && gy == TB_V_ACT); i++) tick();
        rst = 1'b0; hit = 1'b1; miss = 1'b1; key_pulse = 5'h11;
        tick();
        check_reset_vals("rst_pause");
        rst = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            key       = 5'($urandom);
            key_pulse = 5'($urandom) & 5'h0E;
            if ($urandom_range(0, 39) == 0) key_pulse[4] = 1'b1;
            if ($urandom_range(0, 29) == 0) key_pulse[0] = 1'b1;
            hit  = ($urandom_range(0, 3) == 0);
            miss = ($urandom_range(0, 59) == 0);
            rst  = ($urandom_range(0, 699) != 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule

`default_nettype wire
